// File: rtl/reg_scoreboard.sv
// Register in-flight scoreboard: per-register pending-write counters, RAW/WAW-saturation
// stall generation, flush, and a RUN/DRAIN/IDLE halt drain sequence.

module reg_scoreboard_lane #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (flush)          cnt <= '0;
    else if (inc && !dec)    cnt <= cnt + 1'b1;
    else if (dec && !inc)    cnt <= cnt - 1'b1;
  end
endmodule

module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_regWrite,
  input  logic [4:0]       issue_destReg,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  input  logic             halt_req,
  output logic             stall,
  output logic [31:0]      busy_mask,
  output logic [CNT_W+4:0] inflight,
  output logic             drained,
  output logic             wb_err
);
  localparam int IW = CNT_W + 5;
  localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;
  state_t state, state_nxt;

  logic [31:0][CNT_W-1:0] cnt;
  logic [31:0]            inc_v, dec_v;
  logic                   dest_nz, wb_nz, accept;
  logic                   do_inc, do_dec, wb_under;
  logic [IW-1:0]          inflight_nxt;
  logic                   drained_nxt;

  assign cnt[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_lane
    reg_scoreboard_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .inc   (inc_v[r]),
      .dec   (dec_v[r]),
      .cnt   (cnt[r])
    );
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) busy_mask[r] = |cnt[r];
  end

  assign dest_nz = |issue_destReg;
  assign wb_nz   = |wb_rd;

  assign stall = issue_valid & (busy_mask[src1] | busy_mask[src2] |
                 (issue_regWrite & dest_nz & (cnt[issue_destReg] == MAXC)) |
                 (state != RUN));
  assign accept = issue_valid & ~stall;

  // A wb to an empty counter is an underflow: it never decrements, even if an
  // issue to the same register lands in that cycle, so that issue still counts.
  assign do_inc   = ~flush & accept & issue_regWrite & dest_nz;
  assign do_dec   = ~flush & wb_regWrite & wb_nz & (busy_mask[wb_rd]);
  assign wb_under = ~flush & wb_regWrite & wb_nz & ~busy_mask[wb_rd];

  assign inc_v = do_inc ? (32'd1 << issue_destReg) : 32'd0;
  assign dec_v = do_dec ? (32'd1 << wb_rd) : 32'd0;

  assign inflight_nxt = flush ? '0 : inflight + IW'(do_inc) - IW'(do_dec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      wb_err   <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (wb_under) wb_err <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // FSM: next state; drain completion looks at the post-update count
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_req) state_nxt = DRAIN;
      DRAIN:   if (inflight_nxt == '0) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    drained_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drained <= 1'b0;
    else      drained <= drained_nxt;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized + directed bench for reg_scoreboard; a driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_reg_scoreboard;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_regWrite, wb_regWrite, flush, halt_req;
  logic [4:0]       issue_destReg, src1, src2, wb_rd;
  logic             stall, drained, wb_err;
  logic [31:0]      busy_mask;
  logic [CNT_W+4:0] inflight;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regWrite(issue_regWrite),
    .issue_destReg(issue_destReg), .src1(src1), .src2(src2),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
    .flush(flush), .halt_req(halt_req),
    .stall(stall), .busy_mask(busy_mask), .inflight(inflight),
    .drained(drained), .wb_err(wb_err)
  );

  typedef struct packed {
    logic       iv, rw;
    logic [4:0] d, s1, s2;
    logic       wbw;
    logic [4:0] wr;
    logic       fl, hr;
  } stim_t;

  typedef struct {
    bit          stall;
    logic [31:0] busy;
    int          inflight;
    bit          drained;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pending-write count per register, sticky error, halt phase
  int m_cnt[32];
  bit m_err;
  int m_mode;  // 0 running, 1 draining, 2 drained

  function automatic int m_sum();
    int s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && (m_cnt[r] > 0);
  endfunction

  function automatic bit m_stall(input stim_t s);
    return s.iv && (m_busy(s.s1) || m_busy(s.s2) ||
                    (s.rw && s.d != 0 && m_cnt[s.d] == MAXC) || m_mode != 0);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err  = 0;
    m_mode = 0;
  endtask

  task automatic push_exp(input stim_t s);
    exp_t e;
    e.stall    = m_stall(s);
    e.busy     = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (m_cnt[r] > 0);
    e.inflight = m_sum();
    e.drained  = (m_mode == 2);
    e.err      = m_err;
    q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    bit st;
    @(posedge clk); #1;
    issue_valid = s.iv; issue_regWrite = s.rw; issue_destReg = s.d;
    src1 = s.s1; src2 = s.s2; wb_regWrite = s.wbw; wb_rd = s.wr;
    flush = s.fl; halt_req = s.hr;
    push_exp(s);
    st = m_stall(s);
    if (s.fl) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      if (s.wbw && s.wr != 0) begin
        if (m_cnt[s.wr] == 0) m_err = 1;
        else                  m_cnt[s.wr]--;
      end
      if (s.iv && !st && s.rw && s.d != 0) m_cnt[s.d]++;
    end
    if (m_mode == 0 && s.hr)              m_mode = 1;
    else if (m_mode == 1 && m_sum() == 0) m_mode = 2;
  endtask

  task automatic do_reset();
    stim_t z = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    {issue_valid, issue_regWrite, wb_regWrite, flush, halt_req} = '0;
    {issue_destReg, src1, src2, wb_rd} = '0;
    model_clear();
    push_exp(z);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  function automatic stim_t iss(input logic [4:0] d, input logic [4:0] s1, input logic rw);
    stim_t s = '0;
    s.iv = 1; s.rw = rw; s.d = d; s.s1 = s1;
    return s;
  endfunction

  function automatic stim_t wb(input logic [4:0] r);
    stim_t s = '0;
    s.wbw = 1; s.wr = r;
    return s;
  endfunction

  // Monitor: one expectation per driven cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_stall",    int'(stall),     int'(e.stall));
        chk("sb_busy",     int'(busy_mask), int'(e.busy));
        chk("sb_inflight", int'(inflight),  e.inflight);
        chk("sb_drained",  int'(drained),   int'(e.drained));
        chk("sb_wb_err",   int'(wb_err),    int'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0;
    model_clear();
    do_reset();

    // RAW hazard, no same-cycle bypass
    step(iss(8, 0, 1));
    step(iss(1, 8, 1));            #2 chk("raw_stall", stall, 1);
    s = iss(1, 8, 1); s.wbw = 1; s.wr = 8;
    step(s);                       #2 chk("raw_wb_cycle_stall", stall, 1);
    step(iss(1, 8, 1));            #2 chk("raw_after_wb", stall, 0);
    step(wb(1));

    // Saturation at MAXC
    repeat (3) step(iss(5, 0, 1));
    step(iss(5, 0, 1));            #2 chk("sat_stall", stall, 1);
                                      chk("sat_inflight", inflight, 3);
    repeat (3) step(wb(5));

    // Simultaneous issue and wb nets to no change
    step(iss(9, 0, 1));
    s = iss(9, 0, 1); s.wbw = 1; s.wr = 9;
    step(s);
    step('0);                      #2 chk("net_busy9", busy_mask[9], 1);
                                      chk("net_inflight", inflight, 1);
    step(wb(9));

    // Register 0 never tracked
    step(iss(0, 0, 1));            #2 chk("r0_stall", stall, 0);
    step(wb(0));                   #2 chk("r0_busy", busy_mask, 0);
                                      chk("r0_inflight", inflight, 0);
    step('0);                      #2 chk("r0_no_err", wb_err, 0);

    // Flush then underflow
    for (int r = 1; r <= 4; r++) step(iss(5'(r), 0, 1));
    s = '0; s.fl = 1;
    step(s);                       #2 chk("fl_pre_inflight", inflight, 4);
    step(wb(3));                   #2 chk("fl_inflight", inflight, 0);
                                      chk("fl_busy", busy_mask, 0);
    step('0);                      #2 chk("under_err", wb_err, 1);
                                      chk("under_inflight", inflight, 0);

    // Halt drain
    do_reset();
    step(iss(10, 0, 1));
    step(iss(11, 0, 1));
    s = '0; s.hr = 1;
    step(s);
    step(iss(12, 0, 1));           #2 chk("drain_stall", stall, 1);
    step(wb(10));
    step(wb(11));                  #2 chk("drain_not_yet", drained, 0);
    step('0);                      #2 chk("drained", drained, 1);
                                      chk("drain_inflight", inflight, 0);

    // Mid-operation reset
    do_reset();
    step(iss(7, 0, 1));
    step(iss(6, 0, 1));
    do_reset();
    step('0);                      #2 chk("rst_busy", busy_mask, 0);

    // Randomized traffic on a small register window to force conflicts
    for (int i = 0; i < 4000; i++) begin
      s = '0;
      s.iv  = ($urandom_range(0, 99) < 70);
      s.rw  = ($urandom_range(0, 99) < 80);
      s.d   = 5'($urandom_range(0, 7));
      s.s1  = 5'($urandom_range(0, 99) < 50 ? 0 : $urandom_range(0, 7));
      s.s2  = 5'($urandom_range(0, 99) < 70 ? 0 : $urandom_range(0, 7));
      s.wbw = ($urandom_range(0, 99) < 60);
      s.wr  = 5'($urandom_range(0, 7));
      s.fl  = ($urandom_range(0, 99) < 2);
      s.hr  = ($urandom_range(0, 199) == 0);
      if (m_mode == 2 || $urandom_range(0, 399) == 0) do_reset();
      else step(s);
    end

    step('0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of each per-register in-flight counter; MAXC = 2^CNT_W-1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port issue_valid  input  1  decode presents an instruction this cycle.
REQ-005 SHALL have port issue_regWrite  input  1  presented instruction writes a register.
REQ-006 SHALL have port issue_destReg  input  5  destination register of presented instruction.
REQ-007 SHALL have ports src1, src2  input  5 each  source registers (0 = no source).
REQ-008 SHALL have ports wb_regWrite  input  1  and wb_rd  input  5  writeback-side register write.
REQ-009 SHALL have port flush  input  1  discard all in-flight tracking.
REQ-010 SHALL have port halt_req  input  1  halt decoded; begin drain.
REQ-011 SHALL have port stall  output  1  hold decode/fetch this cycle.
REQ-012 SHALL have port busy_mask  output  32  bit r = 1 when counter r is non-zero.
REQ-013 SHALL have port inflight  output  CNT_W+5  sum of all counters.
REQ-014 SHALL have ports drained  output  1  and wb_err  output  1  (sticky underflow flag).

Function
REQ-015 SHALL hold one CNT_W-bit counter per register 1..31; register 0 never tracked, busy_mask[0] always 0.
REQ-016 SHALL drive stall combinationally = issue_valid & (busy[src1] | busy[src2] | (issue_regWrite & dest!=0 & count[dest]==MAXC) | state!=RUN).
REQ-017 SHALL accept an issue when issue_valid & !stall; accepted issue with issue_regWrite & dest!=0 increments count[dest] at the edge.
REQ-018 SHALL decrement count[wb_rd] at the edge when wb_regWrite & wb_rd!=0 & count[wb_rd]!=0.
REQ-019 SHALL, on wb to a register whose count is 0, leave count at 0 and set wb_err (sticky until reset).
REQ-020 SHALL net accepted issue and wb to the same register in one cycle as no change.
REQ-021 SHALL provide no same-cycle bypass: a wb in cycle N clears a dependent stall no earlier than cycle N+1.
REQ-022 SHALL maintain inflight = sum of counters, updated in the same edge as counters, never wrapping.
REQ-023 SHALL, on flush, clear all counters and inflight at the edge; issue and wb in the flush cycle are ignored; wb_err unaffected.
REQ-024 SHALL implement FSM RUN, DRAIN, IDLE; RUN->DRAIN when halt_req at edge; DRAIN->IDLE when inflight==0 (after that edge's updates); IDLE held until reset.
REQ-025 SHALL accept no issues in DRAIN or IDLE while still processing wb; flush in DRAIN empties counters so IDLE follows next edge.
REQ-026 SHALL assert drained only in IDLE (registered).

Reset
REQ-027 SHALL on rst low asynchronously clear all counters, inflight, wb_err, drained, and enter RUN; busy_mask=0, stall=0 while issue_valid=0.
REQ-028 SHALL, on reset mid-drain or mid-operation, discard all tracking; first edge after release operates from empty RUN state.

Verification
REQ-029 SHALL verify RAW: issue dest=8 (cycle 1), next issue src1=8 -> stall=1 until wb_rd=8 in cycle N, stall=0 in N+1.
REQ-030 SHALL verify saturation: three accepted issues dest=5 with no wb -> count[5]=3, fourth issue dest=5 stalls; inflight=3.
REQ-031 SHALL verify simultaneous issue dest=9 and wb_rd=9 with count[9]=1 -> count[9] stays 1, busy_mask[9]=1.
REQ-032 SHALL verify register 0: issue dest=0 and src1=0 -> no stall, busy_mask=0, inflight=0; wb_rd=0 -> no wb_err.
REQ-033 SHALL verify drain: two in flight, halt_req -> stall=1 on any issue, drained=1 one edge after second wb, inflight=0.
REQ-034 SHALL verify flush and underflow: flush with inflight=4 -> next cycle inflight=0, busy_mask=0; subsequent wb_rd=3 -> wb_err=1, counts unchanged.
